serial_subtractor_16bit: RTL and testbench
==========================================

SERIAL_SUBTRACTOR_16BIT -- requirements
Module: serial_subtractor_16bit

Interface
REQ-001 Parameter NUM_BITS, default 16: operand and result width.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  NUM_BITS  minuend, latched when start is accepted.
REQ-006 b  input  NUM_BITS  subtrahend, latched when start is accepted.
REQ-007 borrow_in  input  1  initial borrow, latched when start is accepted.
REQ-008 busy  output  1  high in BUSY and DONE.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 diff  output  NUM_BITS  a - b - borrow_in, modulo 2^NUM_BITS.
REQ-011 borrow_out  output  1  unsigned borrow: high when a < b + borrow_in.
REQ-012 overflow  output  1  two's-complement overflow of the subtraction.

Function
REQ-013 The FSM SHALL have the states IDLE, BUSY and DONE only.
REQ-014 In IDLE with start=1 at a rising edge, the block SHALL:
  - latch a, b and borrow_in;
  - clear the bit counter;
  - move to BUSY.
REQ-015 In BUSY, each rising edge SHALL compute exactly one bit, LSB first, using the 1-bit cell and the registered borrow; the result bit SHALL be shifted into the diff shift register.
REQ-016 After NUM_BITS BUSY edges, the FSM SHALL go to DONE. Timing is fixed: acceptance at edge N gives done=1 in the cycle after edge N+NUM_BITS.
REQ-017 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-018 start SHALL be ignored in BUSY and DONE, with no effect on operands or counter; back-to-back operations therefore have at least one IDLE cycle between them.
REQ-019 diff, borrow_out and overflow SHALL update only on the DONE transition and hold until the next DONE.
REQ-020 borrow_out SHALL equal the borrow leaving the MSB cell.
REQ-021 overflow SHALL equal (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the latched operands.
REQ-022 Internal arithmetic SHALL be exactly NUM_BITS wide; no sign extension; the counter SHALL be wide enough to hold NUM_BITS-1 without wrap.
REQ-023 Simulation-only immediate assertions SHALL $error when start=1 in IDLE and any bit of a, b or borrow_in is not 0/1; there SHALL be no functional effect.

Reset
REQ-024 While rst=1, the block SHALL:
  - hold state in IDLE;
  - drive busy, done, diff, borrow_out and overflow to 0;
  - clear the counter, operand registers and borrow register.
REQ-025 Reset asserted mid-operation (BUSY or DONE) SHALL abort the operation with no done pulse; the first start after rst falls SHALL be processed normally.

Structure
REQ-026 A shared package SHALL hold:
  - the state typedef (IDLE/BUSY/DONE);
  - the NUM_BITS default constant.
REQ-027 The 1-bit cell SHALL be the sub-module full_subtractor_1bit, with inputs x, y, bin and outputs d, bout; it SHALL be instantiated exactly once.
REQ-028 The block SHALL be fully synchronous to clk apart from rst, with no latches and registered outputs only.

Verification
REQ-029 a=0x0005, b=0x0003, bin=0 -> done exactly 16 cycles after acceptance; diff=0x0002, borrow_out=0, overflow=0.
REQ-030 a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, borrow_out=1, overflow=0.
REQ-031 Overflow cases:
  - a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, borrow_out=0, overflow=1;
  - a=0x7FFF, b=0xFFFF, bin=0 -> diff=0x8000, borrow_out=1, overflow=1.
REQ-032 a=0x1234, b=0x1234, bin=1 -> diff=0xFFFF, borrow_out=1, overflow=0; a start pulse during BUSY with other operands -> ignored, same result.
REQ-033 Reset mid-op: rst pulsed at BUSY cycle 7 -> outputs 0 and no done; then a=0x00FF, b=0x000F, bin=0 -> diff=0x00F0, borrow_out=0, overflow=0.

Source files
------------

// File: rtl/serial_subtractor_16bit_pkg.sv
// Shared definitions for the bit-serial subtractor: controller states and
// the default operand width.
package serial_subtractor_16bit_pkg;

  localparam int NUM_BITS_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_subtractor_16bit_pkg

// File: rtl/serial_subtractor_16bit_cell.sv
// One-bit full subtractor: d = x - y - bin, with the borrow out of the bit.
module full_subtractor_1bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  // Borrow when x is 0 and y is 1, or when x equals y and a borrow comes in.
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule : full_subtractor_1bit

// File: rtl/serial_subtractor_16bit.sv
// Bit-serial subtractor: computes a - b - borrow_in one bit per clock,
// LSB first, through a single full_subtractor_1bit cell.
// Results are registered on entry to DONE and held until the next DONE.
module serial_subtractor_16bit
  import serial_subtractor_16bit_pkg::*;
#(
  parameter int NUM_BITS = NUM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                borrow_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] diff,
  output logic                borrow_out,
  output logic                overflow
);

  localparam int MSB   = NUM_BITS - 1;
  // The counter only has to reach NUM_BITS-1, the index of the last bit.
  localparam int CNT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS - 1);

  state_e              state_q;
  logic [NUM_BITS-1:0] a_q;
  logic [NUM_BITS-1:0] b_q;
  logic                bor_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [NUM_BITS-1:0] sr_q;
  logic                busy_q;
  logic                done_q;
  logic [NUM_BITS-1:0] diff_q;
  logic                borrow_out_q;
  logic                overflow_q;

  logic                bit_d;
  logic                bor_d;
  logic [NUM_BITS-1:0] sr_d;

  // The single arithmetic cell, fed by the current bit of each operand.
  full_subtractor_1bit u_cell (
    .x    (a_q[cnt_q]),
    .y    (b_q[cnt_q]),
    .bin  (bor_q),
    .d    (bit_d),
    .bout (bor_d)
  );

  // New result bits enter at the MSB, so after NUM_BITS shifts bit 0 is in place.
  assign sr_d = {bit_d, sr_q[MSB:1]};

  // Controller, serial datapath and registered outputs.
  // NOTE: every register here is assigned with <= so all of them sample the
  // values from before the edge; a blocking = would let later statements see
  // the updated value and silently shorten the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      bor_q        <= 1'b0;
      cnt_q        <= '0;
      sr_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            bor_q   <= borrow_in;
            cnt_q   <= '0;
            sr_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          sr_q  <= sr_d;
          bor_q <= bor_d;
          if (cnt_q == LAST_BIT) begin
            state_q      <= DONE;
            done_q       <= 1'b1;
            diff_q       <= sr_d;
            borrow_out_q <= bor_d;
            // Signed overflow: operands of opposite sign and a result whose
            // sign differs from the minuend.
            overflow_q   <= (a_q[MSB] != b_q[MSB]) && (bit_d != a_q[MSB]);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign overflow   = overflow_q;

`ifndef SYNTHESIS
  // Flag undriven or X operands at the moment a request would be accepted.
  always_comb begin
    if (!rst && start && (state_q == IDLE)) begin
      assert (!$isunknown({a, b, borrow_in}))
        else $error("serial_subtractor_16bit: unknown operand bits at start");
    end
  end
`endif

endmodule : serial_subtractor_16bit

// File: tb/tb_serial_subtractor_16bit.sv
// Scoreboard bench for serial_subtractor_16bit: stimulus pushes hand-computed
// results, a monitor pops and compares on every done pulse.
module tb_serial_subtractor_16bit;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    int           done_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         borrow_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;

  serial_subtractor_16bit #(.NUM_BITS(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: each done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, wanted no pending result", cyc);
      end else begin
        e = sb.pop_front();
        check("diff",       diff,       e.diff);
        check("borrow_out", borrow_out, e.bout);
        check("overflow",   overflow,   e.ovf);
        check("latency",    cyc,        e.done_cyc);
        check("busy_in_done", busy,     1'b1);
      end
    end
  end

  // Wait (bounded) until the block is idle; called at a falling edge.
  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_timeout", busy, 1'b0);
  endtask

  // Issue one request; when push is set, the expected result is queued.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                        input logic [W-1:0] ed, input logic eb, input logic eo,
                        input bit push);
    exp_t e;
    wait_idle();
    start     = 1'b1;
    a         = av;
    b         = bv;
    borrow_in = bi;
    if (push) begin
      e.diff     = ed;
      e.bout     = eb;
      e.ovf      = eo;
      // Acceptance edge is cyc+1; done is seen W edges later.
      e.done_cyc = cyc + 1 + W;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_diff"}, diff, '0);
    check({tag, "_bout"}, borrow_out, 1'b0);
    check({tag, "_ovf"},  overflow, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  initial begin
    int done_before;
    rst       = 1'b1;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    borrow_in = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    //      a        b        bin   diff     bout  ovf
    run_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);
    run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b1);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b1);
    run_op(16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b1);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1);

    // A start pulse with different operands during BUSY must be ignored.
    run_op(16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    start     = 1'b1;
    a         = 16'hAAAA;
    b         = 16'h5555;
    borrow_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    drain();
    // Nothing more may follow the ignored pulse.
    done_before = n_done;
    repeat (W + 4) @(negedge clk);
    check("ignored_start_no_done", n_done, done_before);

    // Reset in the middle of an operation aborts it without a done pulse.
    run_op(16'h4321, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    check("busy_before_abort", busy, 1'b1);
    done_before = n_done;
    rst = 1'b1;
    #1;
    check_outputs_zero("abort");
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 8) @(negedge clk);
    check("abort_no_done", n_done, done_before);
    check_outputs_zero("after_abort");

    run_op(16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b1);
    drain();
    repeat (2) @(negedge clk);
    check("final_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_subtractor_16bit
